seg_pipe_adder: RTL and testbench
=================================

// Module: seg_pipe_adder
// PURPOSE
//  Parametrised, pipelined ripple-carry adder. WIDTH-bit operands split into SEG-bit segments.
//  One segment is summed per pipeline stage, and the carry is registered between stages.
//  Valid/ready handshake on both sides; one result per cycle at full throughput.
//  Arithmetic building block for SP605 datapath tests; replaces single-bit gate-level adders.
// PARAMETERS
//  WIDTH  16  operand/sum width in bits; must be a multiple of SEG (elaboration error otherwise)
//  SEG     4  segment width per pipeline stage; NSEG = WIDTH/SEG = stages = latency
// PORTS
//  clk        in   1      single clock, all logic rising-edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      a/b/cin valid this cycle
//  in_ready   out  1      adder accepts input this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry in to segment 0
//  out_valid  out  1      sum/cout valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result (a + b + cin) mod 2^WIDTH
//  cout       out  1      carry out of MSB
// BEHAVIOUR
//  - Global advance enable: adv = !out_valid | out_ready. in_ready = adv (combinational).
//  - Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
//  - Stage k (0..NSEG-1): adds segment k of the operands plus the registered carry of stage k-1.
//    Stage 0 uses cin. Lower result segments and upper unsummed operand segments shift along
//    with the stage.
//  - Latency: an accepted input appears at the outputs exactly NSEG cycles later if never stalled.
//  - Each stall cycle (adv=0) adds one cycle; while stalled, every stage register
//    (data, carry, valid) holds.
//  - Bubbles: a stage valid bit is 0 when no transfer occurred. Bubbles advance and collapse
//    normally. Results leave strictly in acceptance order; no drop, no duplication.
//  - sum/cout change only when a valid result advances into the output stage.
//    Otherwise they hold their last value.
//  - Reset: all stage valids = 0, all data/carry registers = 0.
//    out_valid = 0, sum = 0, cout = 0, in_ready = 1 in the first cycle after reset.
//  - Reset mid-operation: all in-flight transactions are discarded. No result emerges
//    after rst deasserts unless it is newly accepted.
//  - Simultaneous out and in transfers in the same cycle are legal; full throughput is maintained.
//  - Wrap-around: the sum is modulo 2^WIDTH, and the overflow bit goes to cout only.
//    No signed-overflow flag.
// CONFIGURATION
//  Macro ADDER_SUB_EN:
//  - Defined: an extra input port `sub` (1 bit), sampled with a/b.
//    When sub=1, b is inverted and the effective cin is forced to 1, so sum = a - b.
//    cout=1 means no borrow. When sub=0, behaviour is identical to undefined.
//  - Undefined: no sub port; add only.
// STRUCTURE
//  - Package adder_pkg: function nseg(WIDTH,SEG); localparam for default WIDTH/SEG;
//    typedef of the stage record {valid, carry, partial sum, pending a, pending b}.
//  - Sub-module seg_add_stage: one SEG-bit add slice plus its pipeline register and valid bit,
//    with inputs adv and rst. Instantiated NSEG times in a generate loop.
//  - Top level holds only adv/handshake logic and optional sub pre-inversion.
// TESTING
//  Bench default WIDTH=16, SEG=4 (latency 4).
//  1. rst=1 for 2 cycles -> out_valid=0, sum=0x0000, cout=0, in_ready=1 after release.
//  2. a=0xFFFF, b=0x0001, cin=0, out_ready=1 -> 4 cycles later sum=0x0000, cout=1
//     (full carry ripple).
//  3. Back-to-back (0x1234+0x1111, 0x8000+0x8000, 0x00FF+0x0001, cin=0) on 3 consecutive cycles
//     -> 0x2345/0, 0x0000/1, 0x0100/0 on 3 consecutive cycles.
//  4. Pipeline full, out_ready=0 for 3 cycles -> in_ready=0, sum/out_valid stable.
//     Release -> all results emerge in order, none lost.
//  5. Two transactions in flight, rst pulsed 1 cycle -> out_valid stays 0 for next 5 cycles.
//  6. ADDER_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0;
//     a=0x0007, b=0x0005 -> 0x0002, cout=1.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared widths, stage-count helper and stage record for the segmented pipelined adder
package adder_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG = 4;
  function automatic int nseg(input int width, input int seg);
    return width / seg;
  endfunction
  typedef struct packed {
    logic valid;
    logic carry;
    logic [DEF_WIDTH-1:0] psum;
    logic [DEF_WIDTH-1:0] pa;
    logic [DEF_WIDTH-1:0] pb;
  } stage_t;
endpackage

// File: rtl/seg_add_stage.sv
// seg_add_stage: adds segment K of the operands plus the incoming carry and registers the partial result
module seg_add_stage #(
  parameter int WIDTH = 16,
  parameter int SEG = 4,
  parameter int K = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             v_i,
  input  logic             c_i,
  input  logic [WIDTH-1:0] s_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             v_o,
  output logic             c_o,
  output logic [WIDTH-1:0] s_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o
);
  logic [SEG:0] add;
  logic [WIDTH-1:0] s_d;
  logic v_q, c_q;
  logic [WIDTH-1:0] s_q, a_q, b_q;
  assign add = {1'b0, a_i[K*SEG+:SEG]} + {1'b0, b_i[K*SEG+:SEG]} + {{SEG{1'b0}}, c_i};
  always_comb begin
    s_d = s_i;
    s_d[K*SEG+:SEG] = add[SEG-1:0];
  end
  // data only loads behind a valid token so the last stage holds its result across bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      c_q <= 1'b0;
      s_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else if (adv) begin
      v_q <= v_i;
      if (v_i) begin
        c_q <= add[SEG];
        s_q <= s_d;
        a_q <= a_i;
        b_q <= b_i;
      end
    end
  end
  assign v_o = v_q;
  assign c_o = c_q;
  assign s_o = s_q;
  assign a_o = a_q;
  assign b_o = b_q;
endmodule

// File: rtl/seg_pipe_adder.sv
// seg_pipe_adder: pipelined ripple-carry adder, one SEG-bit segment per stage, valid/ready on both sides.
// Define ADDER_SUB_EN to add a `sub` input that turns the operation into a - b.
module seg_pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int N = nseg(WIDTH, SEG);
  if (WIDTH % SEG != 0) begin : g_bad_cfg
    $error("WIDTH must be a multiple of SEG");
  end
  logic adv;
  logic [N:0] v, c;
  logic [WIDTH-1:0] s [N+1];
  logic [WIDTH-1:0] a_w [N+1];
  logic [WIDTH-1:0] b_w [N+1];
  logic unused;
  assign adv = !v[N] | out_ready;
  assign in_ready = adv;
  assign v[0] = in_valid;
  assign s[0] = '0;
  assign a_w[0] = a;
`ifdef ADDER_SUB_EN
  assign b_w[0] = sub ? ~b : b;
  assign c[0] = cin | sub;
`else
  assign b_w[0] = b;
  assign c[0] = cin;
`endif
  for (genvar k = 0; k < N; k++) begin : g_stage
    seg_add_stage #(.WIDTH(WIDTH), .SEG(SEG), .K(k)) u_stage (
      .clk(clk), .rst(rst), .adv(adv),
      .v_i(v[k]), .c_i(c[k]), .s_i(s[k]), .a_i(a_w[k]), .b_i(b_w[k]),
      .v_o(v[k+1]), .c_o(c[k+1]), .s_o(s[k+1]), .a_o(a_w[k+1]), .b_o(b_w[k+1])
    );
  end
  assign unused = ^{a_w[N], b_w[N]};
  assign out_valid = v[N];
  assign sum = s[N];
  assign cout = c[N];
endmodule

// File: tb/tb_seg_pipe_adder.sv
// tb_seg_pipe_adder: directed and randomized checks of seg_pipe_adder against a queue-based arithmetic model
module tb_seg_pipe_adder;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0;
  logic in_ready, out_valid, cout;
  logic [15:0] a = '0, b = '0, sum;
  logic sub = 1'b0;
  int total = 0, bad = 0;
  logic [16:0] exp_q [$];
  logic prev_stall = 1'b0;
  logic [15:0] prev_sum;
  logic prev_cout;
  always #5 clk = ~clk;
  seg_pipe_adder #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask
  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic sb);
    return sb ? {1'b0, x} + {1'b0, ~y} + 17'd1 : {1'b0, x} + {1'b0, y} + {16'd0, ci};
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall <= 1'b0;
    end else begin
      chk("in_ready", in_ready, !out_valid | out_ready);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_sum", {cout, sum}, {prev_cout, prev_sum});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
        else chk("result", {cout, sum}, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
      prev_stall <= out_valid && !out_ready;
      prev_sum <= sum;
      prev_cout <= cout;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [15:0] x, input logic [15:0] y, input logic ci);
    in_valid = 1'b1; a = x; b = y; cin = ci;
  endtask
  initial begin
    repeat (2) step();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_in_ready", in_ready, 1);
    put(16'hFFFF, 16'h0001, 0);
    step();
    in_valid = 1'b0;
    repeat (2) step();
    chk("lat_early", out_valid, 0);
    step();
    chk("lat_valid", out_valid, 1);
    chk("ripple", {cout, sum}, 17'h10000);
    repeat (2) step();
    put(16'h1234, 16'h1111, 0); step();
    put(16'h8000, 16'h8000, 0); step();
    put(16'h00FF, 16'h0001, 0); step();
    in_valid = 1'b0;
    step();
    chk("b2b0", {out_valid, cout, sum}, {1'b1, 17'h02345});
    step();
    chk("b2b1", {out_valid, cout, sum}, {1'b1, 17'h10000});
    step();
    chk("b2b2", {out_valid, cout, sum}, {1'b1, 17'h00100});
    step();
    chk("b2b_idle", out_valid, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      put(16'($urandom), 16'($urandom), 1'($urandom));
      step();
    end
    chk("full_in_ready", in_ready, 0);
    chk("full_valid", out_valid, 1);
    in_valid = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    repeat (10) step();
    chk("drain_empty", exp_q.size(), 0);
    put(16'h0101, 16'h0202, 0); step();
    put(16'h0303, 16'h0404, 1); step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("flush_valid", out_valid, 0);
      step();
    end
`ifdef ADDER_SUB_EN
    sub = 1'b1;
    put(16'h0005, 16'h0007, 0); step();
    put(16'h0007, 16'h0005, 0); step();
    in_valid = 1'b0; sub = 1'b0;
    step();
    chk("sub0", {out_valid, cout, sum}, {1'b1, 17'h0FFFE});
    step();
    chk("sub1", {out_valid, cout, sum}, {1'b1, 17'h10002});
    repeat (3) step();
`endif
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(3) != 0);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
`ifdef ADDER_SUB_EN
      sub = 1'($urandom);
`endif
      out_ready = ($urandom_range(3) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) step();
    chk("final_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
